reg_exchange_ctrl: RTL and testbench

Race-free two-register exchange controller: holds two WIDTH-bit values A and B, accepts a swap request over a valid/ready handshake, and exchanges them either atomically in one clock or through a three-step temporary-register sequence. It serves as the write/exchange side of the flip-flop swap experiments. A requester drives loads and swap requests; `done` and the two register outputs are read back.

---
 rtl/reg_exchange_pkg.sv | 14 +
 rtl/reg_exchange_ctrl.sv | 103 ++++++++++
 tb/tb_reg_exchange_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_exchange_pkg.sv
// Shared types and default sizes for the register exchange controller.
package reg_exchange_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefCntW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StMove,
    StRestore,
    StDone
  } state_e;

endpackage

// File: rtl/reg_exchange_ctrl.sv
// Two-register exchange controller: sequential three-step swap through a temp register,
// or a single-cycle atomic swap when REG_EXCHANGE_ATOMIC_EN is defined.
module reg_exchange_ctrl
  import reg_exchange_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] din,
  input  logic             swap_req,
  output logic             swap_rdy,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  output logic             done,
  output logic             ld_err,
  output logic [CNT_W-1:0] swap_cnt
);

  logic accept;
  logic load_req;

  assign load_req = ld_a | ld_b;
  assign accept   = swap_req & swap_rdy;

`ifdef REG_EXCHANGE_ATOMIC_EN

  assign swap_rdy = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a      <= '0;
      q_b      <= '0;
      swap_cnt <= '0;
      done     <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      done   <= accept;
      ld_err <= load_req & accept;
      if (accept) begin
        q_a      <= q_b;
        q_b      <= q_a;
        swap_cnt <= swap_cnt + CNT_W'(1);
      end else begin
        if (ld_a) q_a <= din;
        if (ld_b) q_b <= din;
      end
    end
  end

`else

  state_e           state_q;
  logic [WIDTH-1:0] temp_q;

  assign swap_rdy = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      temp_q   <= '0;
      q_a      <= '0;
      q_b      <= '0;
      swap_cnt <= '0;
      done     <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      done   <= (state_q == StRestore);
      // Loads lose to a same-cycle accept and are refused outside IDLE.
      ld_err <= load_req & (accept | (state_q != StIdle));
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            temp_q  <= q_a;
            state_q <= StMove;
          end else begin
            if (ld_a) q_a <= din;
            if (ld_b) q_b <= din;
          end
        end
        StMove: begin
          q_a     <= q_b;
          state_q <= StRestore;
        end
        StRestore: begin
          q_b      <= temp_q;
          swap_cnt <= swap_cnt + CNT_W'(1);
          state_q  <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_reg_exchange_ctrl.sv
// Directed self-checking bench for reg_exchange_ctrl; honours REG_EXCHANGE_ATOMIC_EN.
module tb_reg_exchange_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ld_a;
  logic       ld_b;
  logic [7:0] din;
  logic       swap_req;
  logic       swap_rdy;
  logic [7:0] q_a;
  logic [7:0] q_b;
  logic       done;
  logic       ld_err;
  logic [7:0] swap_cnt;

  logic       swap_rdy2;
  logic [7:0] q_a2;
  logic [7:0] q_b2;
  logic       done2;
  logic       ld_err2;
  logic [1:0] swap_cnt2;

  int n_cmp;
  int n_fail;

  reg_exchange_ctrl #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .din      (din),
    .swap_req (swap_req),
    .swap_rdy (swap_rdy),
    .q_a      (q_a),
    .q_b      (q_b),
    .done     (done),
    .ld_err   (ld_err),
    .swap_cnt (swap_cnt)
  );

  reg_exchange_ctrl #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .din      (din),
    .swap_req (swap_req),
    .swap_rdy (swap_rdy2),
    .q_a      (q_a2),
    .q_b      (q_b2),
    .done     (done2),
    .ld_err   (ld_err2),
    .swap_cnt (swap_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    ld_a = 1'b0; ld_b = 1'b0; din = '0; swap_req = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ld_a = 1'b1; din = a;
    step();
    ld_a = 1'b0; ld_b = 1'b1; din = b;
    step();
    ld_b = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (q_a !== 8'h00 || q_b !== 8'h00 || swap_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs: q_a=%h q_b=%h cnt=%h, expected 00 00 00", q_a, q_b, swap_cnt);
    end
    n_cmp++;
    if (done !== 1'b0 || ld_err !== 1'b0 || swap_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: done=%b ld_err=%b rdy=%b, expected 0 0 1", done, ld_err, swap_rdy);
    end
    load_ab(8'h3C, 8'hA5);
    n_cmp++;
    if (q_a !== 8'h3C || q_b !== 8'hA5) begin
      n_fail++;
      $display("FAIL load: q_a=%h q_b=%h, expected 3c a5", q_a, q_b);
    end
  endtask

`ifndef REG_EXCHANGE_ATOMIC_EN
  task automatic test_seq_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_cmp++;
    if (swap_rdy !== 1'b0 || q_a !== 8'h3C) begin
      n_fail++;
      $display("FAIL seq_accept: rdy=%b q_a=%h, expected 0 3c", swap_rdy, q_a);
    end
    step();
    n_cmp++;
    if (q_a !== 8'hA5 || q_b !== 8'hA5 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_restore: q_a=%h q_b=%h done=%b, expected a5 a5 0", q_a, q_b, done);
    end
    step();
    n_cmp++;
    if (q_b !== 8'h3C || done !== 1'b1 || swap_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL seq_done: q_b=%h done=%b cnt=%0d, expected 3c 1 1", q_b, done, swap_cnt);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || swap_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_idle: done=%b rdy=%b, expected 0 1", done, swap_rdy);
    end
  endtask

  task automatic test_load_collision();
    load_ab(8'h5A, 8'hC3);
    ld_a = 1'b1; din = 8'h11; swap_req = 1'b1;
    step();
    ld_a = 1'b0; swap_req = 1'b0;
    n_cmp++;
    if (ld_err !== 1'b1 || q_a !== 8'h5A) begin
      n_fail++;
      $display("FAIL collide_accept: ld_err=%b q_a=%h, expected 1 5a", ld_err, q_a);
    end
    ld_b = 1'b1; din = 8'h77;
    step();
    ld_b = 1'b0;
    n_cmp++;
    if (ld_err !== 1'b1 || q_b !== 8'hC3) begin
      n_fail++;
      $display("FAIL load_busy: ld_err=%b q_b=%h, expected 1 c3", ld_err, q_b);
    end
    step();
    n_cmp++;
    if (ld_err !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_done: ld_err=%b done=%b, expected 0 1", ld_err, done);
    end
    step();
    n_cmp++;
    if (q_a !== 8'hC3 || q_b !== 8'h5A || swap_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL collide_final: q_a=%h q_b=%h cnt=%0d, expected c3 5a 2", q_a, q_b, swap_cnt);
    end
  endtask

  task automatic test_held_req();
    logic exp_rdy;
    swap_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_rdy = ((k % 4) == 3);
      n_cmp++;
      if (swap_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL held_rdy[%0d]: rdy=%b, expected %b", k, swap_rdy, exp_rdy);
      end
    end
    swap_req = 1'b0;
    n_cmp++;
    if (swap_cnt !== 8'd4 || q_a !== 8'hC3 || q_b !== 8'h5A) begin
      n_fail++;
      $display("FAIL held_final: cnt=%0d q_a=%h q_b=%h, expected 4 c3 5a", swap_cnt, q_a, q_b);
    end
  endtask

  task automatic test_reset_mid_move();
    int seen_done;
    seen_done = 0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (q_a !== 8'h00 || q_b !== 8'h00 || swap_cnt !== 8'h00 || swap_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_move: q_a=%h q_b=%h cnt=%0d rdy=%b, expected 00 00 0 1",
               q_a, q_b, swap_cnt, swap_rdy);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (done !== 1'b0) seen_done++;
      step();
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: done cycles=%0d, expected 0", seen_done);
    end
  endtask
`else
  task automatic test_atomic();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] tmp;
    exp_a = 8'h3C;
    exp_b = 8'hA5;
    swap_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      tmp = exp_a; exp_a = exp_b; exp_b = tmp;
      n_cmp++;
      if (q_a !== exp_a || q_b !== exp_b || done !== 1'b1 || swap_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL atomic[%0d]: q_a=%h q_b=%h done=%b rdy=%b, expected %h %h 1 1",
                 k, q_a, q_b, done, swap_rdy, exp_a, exp_b);
      end
    end
    swap_req = 1'b0;
    n_cmp++;
    if (swap_cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL atomic_cnt: cnt=%0d, expected 4", swap_cnt);
    end
    ld_a = 1'b1; din = 8'h11; swap_req = 1'b1;
    step();
    ld_a = 1'b0; swap_req = 1'b0;
    n_cmp++;
    if (ld_err !== 1'b1 || q_a !== 8'hA5 || q_b !== 8'h3C) begin
      n_fail++;
      $display("FAIL atomic_collide: ld_err=%b q_a=%h q_b=%h, expected 1 a5 3c", ld_err, q_a, q_b);
    end
    step();
    n_cmp++;
    if (ld_err !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL atomic_quiet: ld_err=%b done=%b, expected 0 0", ld_err, done);
    end
  endtask
`endif

  task automatic test_cnt_wrap();
    logic [1:0] exp_cnt [5];
    int         waited;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      waited = 0;
      while (done2 !== 1'b1 && waited < 8) begin
        step();
        waited++;
      end
      n_cmp++;
      if (done2 !== 1'b1 || swap_cnt2 !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL cnt_wrap[%0d]: done=%b cnt=%0d, expected 1 %0d", i, done2, swap_cnt2,
                 exp_cnt[i]);
      end
      step();
    end
    n_cmp++;
    if (swap_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL cnt_wide: cnt=%0d, expected 5", swap_cnt);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    ld_a = 1'b0; ld_b = 1'b0; din = '0; swap_req = 1'b0;
    test_reset();
`ifndef REG_EXCHANGE_ATOMIC_EN
    test_seq_swap();
    test_load_collision();
    test_held_req();
    test_reset_mid_move();
`else
    test_atomic();
`endif
    test_cnt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
